// File: rtl/ingress_shaper_if.sv
// Bundle between traffic source, ingress shaper and downstream switch port.
// The shaper takes the slave side; the environment takes the master side.
interface ingress_shaper_if #(
  parameter int PACKET_WIDTH = 16
);
  logic                    up_valid;
  logic                    up_ready;
  logic [PACKET_WIDTH-1:0] up_data;
  logic                    port_valid_in;
  logic [PACKET_WIDTH-1:0] port_data;
  logic                    port_full;

  modport slave (
    input  up_valid,
    input  up_data,
    input  port_full,
    output up_ready,
    output port_valid_in,
    output port_data
  );

  modport master (
    output up_valid,
    output up_data,
    output port_full,
    input  up_ready,
    input  port_valid_in,
    input  port_data
  );
endinterface

// File: rtl/ingress_shaper.sv
// Ingress shaper: buffers source packets and forwards them into a switch port
// only while its FIFO has room, optionally paced by a token bucket.
module ingress_shaper #(
  parameter int PACKET_WIDTH = 16,
  parameter int DEPTH        = 4,
  parameter int BUCKET_MAX   = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  ingress_shaper_if.slave          bus,
  input  logic                     rate_en,
  input  logic [7:0]               rate_period,
  output logic [$clog2(DEPTH):0]   fill_level,
  output logic [7:0]               tokens,
  output logic [15:0]              cnt_accepted,
  output logic [15:0]              cnt_sent,
  output logic [15:0]              cnt_rejected
);

  localparam int              AW      = $clog2(DEPTH);
  localparam int              FW      = AW + 1;
  localparam logic [FW-1:0]   DEPTH_L = FW'(DEPTH);
  localparam logic [7:0]      BMAX    = 8'(BUCKET_MAX);
  localparam logic [15:0]     CNT_MAX = 16'hFFFF;

  logic [PACKET_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]           wr_ptr;
  logic [AW-1:0]           rd_ptr;
  logic [FW-1:0]           fill_q;
  logic [7:0]              timer_q;
  logic [7:0]              tokens_q;
  logic [15:0]             cnt_accepted_q;
  logic [15:0]             cnt_sent_q;
  logic [15:0]             cnt_rejected_q;

  logic                    handshake;
  logic                    legal;
  logic                    push;
  logic                    reject;
  logic                    send;
  logic                    wrap;
  logic [7:0]              limit_m1;

  always_comb begin
    bus.up_ready = !rst && (fill_q < DEPTH_L);
    handshake    = bus.up_valid && bus.up_ready;
    legal        = (bus.up_data[7:4] != 4'b0000);
    push         = handshake && legal;
    reject       = handshake && !legal;
    // port_full gates the send combinationally so nothing is ever offered to a full port
    send         = !rst && (fill_q != '0) && !bus.port_full &&
                   (!rate_en || (tokens_q != 8'd0));
    bus.port_valid_in = send;
    bus.port_data     = send ? mem[rd_ptr] : '0;
    // a period of 0 behaves as 1; comparing with >= lets a shortened period wrap at once
    limit_m1     = (rate_period == 8'd0) ? 8'd0 : rate_period - 8'd1;
    wrap         = rate_en && (timer_q >= limit_m1);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.up_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      fill_q         <= '0;
      timer_q        <= 8'd0;
      tokens_q       <= BMAX;
      cnt_accepted_q <= 16'd0;
      cnt_sent_q     <= 16'd0;
      cnt_rejected_q <= 16'd0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (send) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, send})
        2'b10:   fill_q <= fill_q + 1'b1;
        2'b01:   fill_q <= fill_q - 1'b1;
        default: fill_q <= fill_q;
      endcase

      if (!rate_en) begin
        timer_q  <= 8'd0;
        tokens_q <= BMAX;
      end else begin
        timer_q <= wrap ? 8'd0 : timer_q + 8'd1;
        case ({wrap, send})
          2'b10:   tokens_q <= (tokens_q < BMAX) ? tokens_q + 8'd1 : tokens_q;
          2'b01:   tokens_q <= tokens_q - 8'd1;
          default: tokens_q <= tokens_q;
        endcase
      end

      cnt_accepted_q <= (push   && cnt_accepted_q != CNT_MAX) ? cnt_accepted_q + 16'd1 : cnt_accepted_q;
      cnt_sent_q     <= (send   && cnt_sent_q     != CNT_MAX) ? cnt_sent_q     + 16'd1 : cnt_sent_q;
      cnt_rejected_q <= (reject && cnt_rejected_q != CNT_MAX) ? cnt_rejected_q + 16'd1 : cnt_rejected_q;
    end
  end

  assign fill_level   = fill_q;
  assign tokens       = tokens_q;
  assign cnt_accepted = cnt_accepted_q;
  assign cnt_sent     = cnt_sent_q;
  assign cnt_rejected = cnt_rejected_q;

endmodule

// File: tb/tb_ingress_shaper.sv
// Scoreboard bench for ingress_shaper: legal packets are queued as they are
// handshaken and compared in order against every port_valid_in cycle.
module tb_ingress_shaper;

  localparam int PW = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rate_en = 1'b0;
  logic [7:0]  rate_period = 8'd10;
  logic [2:0]  fill_level;
  logic [7:0]  tokens;
  logic [15:0] cnt_accepted;
  logic [15:0] cnt_sent;
  logic [15:0] cnt_rejected;

  ingress_shaper_if #(.PACKET_WIDTH(PW)) bus ();

  ingress_shaper #(.PACKET_WIDTH(PW), .DEPTH(4), .BUCKET_MAX(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .rate_en      (rate_en),
    .rate_period  (rate_period),
    .fill_level   (fill_level),
    .tokens       (tokens),
    .cnt_accepted (cnt_accepted),
    .cnt_sent     (cnt_sent),
    .cnt_rejected (cnt_rejected)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          n_sent = 0;
  int          max_tokens = 0;
  int          last_hs_cyc = 0;
  int          acc_model = 0;
  int          rej_model = 0;
  logic [15:0] exp_q [$];
  int          send_cyc [$];
  logic [15:0] mon_exp;

  always @(posedge clk) cyc++;

  // monitor: sampled mid-cycle, after the inputs for the coming edge are settled
  always @(negedge clk) begin
    if (int'(tokens) > max_tokens) max_tokens = int'(tokens);
    checks++;
    if (bus.port_valid_in === 1'b1) begin
      n_sent++;
      send_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_send: got %h, expected no send", bus.port_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (bus.port_data !== mon_exp) begin
          errors++;
          $display("FAIL sb_data: got %h, expected %h", bus.port_data, mon_exp);
        end
      end
    end else if (bus.port_data !== 16'h0000) begin
      errors++;
      $display("FAIL idle_data: got %h, expected 0000", bus.port_data);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] pk(input logic [3:0] src, input logic [3:0] tgt,
                                     input logic [1:0] typ, input logic [5:0] pay);
    return {pay, typ, tgt, src};
  endfunction

  task automatic push(input logic [15:0] d);
    bit ok = 1'b0;
    bus.up_valid = 1'b1;
    bus.up_data  = d;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (bus.up_ready === 1'b1) begin
        if (d[7:4] != 4'h0) begin
          exp_q.push_back(d);
          acc_model++;
        end else begin
          rej_model++;
        end
        last_hs_cyc = cyc + 1;
        ok = 1'b1;
      end
      @(posedge clk); #1;
    end
    bus.up_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: got no up_ready for %h, expected handshake", d);
    end
  endtask

  task automatic wait_sent(input int target, input int budget);
    for (int i = 0; i < budget && n_sent < target; i++) @(posedge clk);
    @(posedge clk); #1;
    checks++;
    if (n_sent != target) begin
      errors++;
      $display("FAIL wait_sent: got %0d sends, expected %0d", n_sent, target);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.up_valid = 1'b0;
    bus.up_data = '0;
    bus.port_full = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.up_ready !== 1'b0) begin errors++; $display("FAIL rst_up_ready: got %b expected 0", bus.up_ready); end
    checks++; if (bus.port_valid_in !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", bus.port_valid_in); end
    checks++; if (fill_level !== 3'd0) begin errors++; $display("FAIL rst_fill: got %0d expected 0", fill_level); end
    checks++; if (tokens !== 8'd8) begin errors++; $display("FAIL rst_tokens: got %0d expected 8", tokens); end
    checks++; if ({cnt_accepted, cnt_sent, cnt_rejected} !== 48'd0) begin errors++; $display("FAIL rst_counters: got %h/%h/%h expected 0/0/0", cnt_accepted, cnt_sent, cnt_rejected); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.up_ready !== 1'b1) begin errors++; $display("FAIL post_rst_up_ready: got %b expected 1", bus.up_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_post_reset_flow();
    int base = n_sent;
    int hs0;
    send_cyc.delete();
    push(pk(4'h1, 4'h1, 2'd0, 6'h11)); hs0 = last_hs_cyc;
    push(pk(4'h2, 4'h2, 2'd1, 6'h22));
    push(pk(4'h3, 4'h4, 2'd2, 6'h33));
    wait_sent(base + 3, 20);
    checks++; if (send_cyc.size() != 3) begin errors++; $display("FAIL flow_nsends: got %0d expected 3", send_cyc.size()); end
    checks++; if (send_cyc[0] != hs0) begin errors++; $display("FAIL flow_latency: got cycle %0d expected %0d", send_cyc[0], hs0); end
    checks++; if (send_cyc[2] != hs0 + 2) begin errors++; $display("FAIL flow_consecutive: got cycle %0d expected %0d", send_cyc[2], hs0 + 2); end
    checks++; if (cnt_sent !== 16'd3) begin errors++; $display("FAIL flow_cnt_sent: got %0d expected 3", cnt_sent); end
  endtask

  task automatic test_backpressure();
    int  base = n_sent;
    bit  stuck_ok = 1'b1;
    bus.port_full = 1'b1;
    for (int i = 0; i < 4; i++) push(pk(4'(i), 4'h8, 2'd3, 6'(8'h30 + i)));
    @(negedge clk);
    checks++; if (bus.up_ready !== 1'b0) begin errors++; $display("FAIL bp_up_ready_full: got %b expected 0", bus.up_ready); end
    checks++; if (fill_level !== 3'd4) begin errors++; $display("FAIL bp_fill: got %0d expected 4", fill_level); end
    bus.up_valid = 1'b1;
    bus.up_data  = pk(4'h5, 4'h3, 2'd0, 6'h35);
    repeat (3) begin
      @(negedge clk);
      if (bus.up_ready !== 1'b0) stuck_ok = 1'b0;
    end
    checks++; if (!stuck_ok) begin errors++; $display("FAIL bp_ready_stuck: got up_ready high while full, expected low"); end
    checks++; if (n_sent != base) begin errors++; $display("FAIL bp_no_send: got %0d sends expected %0d", n_sent, base); end
    @(posedge clk); #1;
    bus.up_valid  = 1'b0;
    bus.port_full = 1'b0;
    @(negedge clk);
    checks++; if (bus.port_valid_in !== 1'b1 || bus.up_ready !== 1'b0) begin errors++; $display("FAIL bp_release: got valid=%b ready=%b expected valid=1 ready=0", bus.port_valid_in, bus.up_ready); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (bus.up_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_return: got %b expected 1", bus.up_ready); end
    @(posedge clk); #1;
    push(pk(4'h5, 4'h3, 2'd0, 6'h35));
    push(pk(4'h6, 4'hC, 2'd1, 6'h36));
    wait_sent(base + 6, 30);
    checks++; if (fill_level !== 3'd0) begin errors++; $display("FAIL bp_drained: got %0d expected 0", fill_level); end
  endtask

  task automatic test_illegal_target();
    int base = n_sent;
    push(pk(4'h7, 4'h2, 2'd0, 6'h07));
    push(pk(4'h8, 4'h0, 2'd1, 6'h08));
    push(pk(4'h9, 4'h1, 2'd2, 6'h09));
    wait_sent(base + 2, 20);
    repeat (3) @(posedge clk); #1;
    checks++; if (n_sent != base + 2) begin errors++; $display("FAIL ill_sends: got %0d expected %0d", n_sent, base + 2); end
    checks++; if (cnt_rejected !== 16'(rej_model)) begin errors++; $display("FAIL ill_rejected: got %0d expected %0d", cnt_rejected, rej_model); end
    checks++; if (cnt_accepted !== 16'(acc_model)) begin errors++; $display("FAIL ill_accepted: got %0d expected %0d", cnt_accepted, acc_model); end
    checks++; if (cnt_sent !== 16'(acc_model)) begin errors++; $display("FAIL ill_cnt_sent: got %0d expected %0d", cnt_sent, acc_model); end
  endtask

  task automatic test_rate_limit();
    int base;
    bit burst_ok = 1'b1;
    bit pace_ok  = 1'b1;
    bus.port_full = 1'b1;
    for (int i = 0; i < 4; i++) push(pk(4'h1, 4'h4, 2'd0, 6'(i)));
    base = n_sent;
    send_cyc.delete();
    max_tokens  = 0;
    rate_period = 8'd10;
    rate_en     = 1'b1;
    bus.port_full = 1'b0;
    fork
      for (int i = 4; i < 20; i++) push(pk(4'h2, 4'h4, 2'd1, 6'(i)));
      wait_sent(base + 20, 300);
    join
    for (int i = 1; i < 8; i++) if (send_cyc[i] - send_cyc[i-1] != 1) burst_ok = 1'b0;
    for (int i = 9; i < 20; i++) if (send_cyc[i] - send_cyc[i-1] != 10) pace_ok = 1'b0;
    checks++; if (!burst_ok) begin errors++; $display("FAIL rate_burst: got gaps in first 8 sends, expected back-to-back"); end
    checks++; if (send_cyc[8] - send_cyc[0] != 10) begin errors++; $display("FAIL rate_first_refill: got offset %0d expected 10", send_cyc[8] - send_cyc[0]); end
    checks++; if (!pace_ok) begin errors++; $display("FAIL rate_pace: got spacing other than 10, expected 10"); end
    checks++; if (max_tokens > 8) begin errors++; $display("FAIL rate_tokens_max: got %0d expected <= 8", max_tokens); end
    rate_en = 1'b0;
    @(posedge clk); #1;
    checks++; if (tokens !== 8'd8) begin errors++; $display("FAIL rate_disabled_tokens: got %0d expected 8", tokens); end
  endtask

  task automatic test_reset_mid();
    int base;
    bus.port_full = 1'b1;
    for (int i = 0; i < 3; i++) push(pk(4'hA, 4'h2, 2'd0, 6'(i)));
    rst = 1'b1;
    bus.port_full = 1'b0;
    exp_q.delete();
    @(negedge clk);
    checks++; if (bus.port_valid_in !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %b expected 0", bus.port_valid_in); end
    @(posedge clk); #1;
    rst = 1'b0;
    acc_model = 0;
    rej_model = 0;
    base = n_sent;
    @(negedge clk);
    checks++; if (fill_level !== 3'd0) begin errors++; $display("FAIL mid_fill: got %0d expected 0", fill_level); end
    checks++; if (tokens !== 8'd8) begin errors++; $display("FAIL mid_tokens: got %0d expected 8", tokens); end
    checks++; if ({cnt_accepted, cnt_sent, cnt_rejected} !== 48'd0) begin errors++; $display("FAIL mid_counters: got %h/%h/%h expected 0/0/0", cnt_accepted, cnt_sent, cnt_rejected); end
    repeat (6) @(posedge clk); #1;
    checks++; if (n_sent != base) begin errors++; $display("FAIL mid_stale: got %0d sends expected %0d", n_sent, base); end
  endtask

  task automatic test_saturation();
    int base = n_sent;
    force dut.cnt_sent_q = 16'hFFFE;
    @(posedge clk); #1;
    release dut.cnt_sent_q;
    @(negedge clk);
    checks++; if (cnt_sent !== 16'hFFFE) begin errors++; $display("FAIL sat_preset: got %h expected fffe", cnt_sent); end
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) push(pk(4'hB, 4'h1, 2'd3, 6'(i + 40)));
    wait_sent(base + 3, 20);
    checks++; if (cnt_sent !== 16'hFFFF) begin errors++; $display("FAIL sat_cnt_sent: got %h expected ffff", cnt_sent); end
    checks++; if (cnt_accepted !== 16'(acc_model)) begin errors++; $display("FAIL sat_accepted: got %0d expected %0d", cnt_accepted, acc_model); end
  endtask

  initial begin
    test_reset();
    test_post_reset_flow();
    test_backpressure();
    test_illegal_target();
    test_rate_limit();
    test_reset_mid();
    test_saturation();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL sb_leftover: got %0d pending, expected 0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
